// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared constants and types for the result-writer data memory.
//   DEPTH      : number of 32-bit words in the memory
//   AW         : word-index width, clog2(DEPTH)
//   DW         : data width
//   DEPTH_32   : DEPTH sized to the 32-bit core address, for range checks
//   DEPTH_HWM  : DEPTH sized to the AW+1 high-water-mark width
//   dump_state_t : states of the dump engine
package dmem_pkg;

    localparam int DEPTH = 8100;
    localparam int AW    = 13;
    localparam int DW    = 32;

    localparam logic [31:0]   DEPTH_32  = 32'(DEPTH);
    localparam logic [AW:0]   DEPTH_HWM = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   HWM_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        DONE
    } dump_state_t;

endpackage

// File: rtl/dmem_dp_ram.sv
// dmem_dp_ram
// Word-addressed storage with one synchronous write port and two
// combinational read ports (core load path and dump engine).
// The array has no reset so its contents survive a reset of the control logic.
//   clk      : write clock, rising edge
//   i_we     : write strobe (already qualified by the caller)
//   i_waddr  : write word index
//   i_wdata  : write data
//   i_raddrA : core read index       -> o_rdataA
//   i_raddrB : dump engine read index -> o_rdataB
// Reads of an index at or beyond DEPTH return zero rather than an undefined word.
module dmem_dp_ram
    import dmem_pkg::*;
(
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddrA,
    output logic [DW-1:0] o_rdataA,
    input  logic [AW-1:0] i_raddrB,
    output logic [DW-1:0] o_rdataB
);

    logic [DW-1:0] r_mem [DEPTH];

    // Single write port; a read of the same word in the same cycle still
    // sees the old contents because the update lands at the clock edge.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // The AW-bit index can reach past DEPTH, so both read ports are guarded.
    always_comb begin
        o_rdataA = '0;
        o_rdataB = '0;
        if ({1'b0, i_raddrA} < DEPTH_HWM) begin
            o_rdataA = r_mem[i_raddrA];
        end
        if ({1'b0, i_raddrB} < DEPTH_HWM) begin
            o_rdataB = r_mem[i_raddrB];
        end
    end

endmodule

// File: rtl/dmem_result_writer.sv
// dmem_result_writer
// Writable data memory for processed samples stored by the MEM stage, plus a
// dump engine that streams words 0..hwm-1 to an external sink over valid/ready.
//   clk, reset         : clock (rising edge) and asynchronous active-high reset
//   we, address, wd    : core store strobe, word index, store data
//   rd                 : core load data, combinational, zero when out of range
//   dump_start         : one-cycle request to begin a dump (ignored unless idle)
//   dump_data/valid    : registered stream word and its valid flag
//   dump_ready         : sink accepts the current word
//   dump_done          : one-cycle pulse after the last word is accepted
//   busy               : dump engine is not idle
//   hwm                : high-water mark, largest written index + 1
//   err_oor, err_busy  : sticky error flags, cleared only by reset
module dmem_result_writer
    import dmem_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [31:0]   address,
    input  logic [DW-1:0] wd,
    output logic [DW-1:0] rd,
    input  logic          dump_start,
    output logic [DW-1:0] dump_data,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic          dump_done,
    output logic          busy,
    output logic [AW:0]   hwm,
    output logic          err_oor,
    output logic          err_busy
);

    dump_state_t   r_state;
    dump_state_t   w_stateNext;
    logic [AW-1:0] r_ptr;
    logic [AW:0]   r_hwm;
    logic [DW-1:0] r_dumpData;
    logic          r_dumpValid;
    logic          r_errOor;
    logic          r_errBusy;

    logic          w_addrInRange;
    logic [AW-1:0] w_coreIdx;
    logic          w_idle;
    logic          w_wrAccept;
    logic [AW:0]   w_wrEnd;
    logic [AW:0]   w_hwmNext;
    logic          w_lastWord;
    logic          w_accept;
    logic [AW-1:0] w_dumpIdx;
    logic [DW-1:0] w_ramCore;
    logic [DW-1:0] w_ramDump;

    logic          w_ptrClr;
    logic          w_ptrStep;
    logic          w_capture;
    logic          w_validSet;
    logic          w_validClr;
    logic          w_done;

    assign w_addrInRange = (address < DEPTH_32);
    assign w_coreIdx     = address[AW-1:0];
    assign w_idle        = (r_state == IDLE);
    assign w_wrAccept    = we && w_idle && w_addrInRange;
    assign w_wrEnd       = {1'b0, w_coreIdx} + HWM_ONE;

    // The high-water mark as it will be after this edge; the IDLE start
    // decision uses it so a write landing alongside dump_start is dumped too.
    assign w_hwmNext = (w_wrAccept && (w_wrEnd > r_hwm)) ? w_wrEnd : r_hwm;

    assign w_lastWord = ({1'b0, r_ptr} == (r_hwm - HWM_ONE));
    assign w_accept   = r_dumpValid && dump_ready;

    // In SEND the next word is prefetched so an accepted word is replaced
    // in the same edge, giving one word per cycle under constant ready.
    assign w_dumpIdx = (r_state == SEND) ? (r_ptr + PTR_ONE) : r_ptr;

    dmem_dp_ram u_ram (
        .clk      (clk),
        .i_we     (w_wrAccept),
        .i_waddr  (w_coreIdx),
        .i_wdata  (wd),
        .i_raddrA (w_coreIdx),
        .o_rdataA (w_ramCore),
        .i_raddrB (w_dumpIdx),
        .o_rdataB (w_ramDump)
    );

    assign rd = w_addrInRange ? w_ramCore : '0;

    // Dump engine state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Dump engine next-state and datapath controls. An empty memory skips
    // straight to DONE so the sink still sees a completion pulse.
    always_comb begin
        w_stateNext = r_state;
        w_ptrClr    = 1'b0;
        w_ptrStep   = 1'b0;
        w_capture   = 1'b0;
        w_validSet  = 1'b0;
        w_validClr  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (dump_start) begin
                    if (w_hwmNext != '0) begin
                        w_ptrClr    = 1'b1;
                        w_stateNext = LOAD;
                    end else begin
                        w_stateNext = DONE;
                    end
                end
            end
            LOAD: begin
                w_capture   = 1'b1;
                w_validSet  = 1'b1;
                w_stateNext = SEND;
            end
            SEND: begin
                if (w_accept) begin
                    if (w_lastWord) begin
                        w_validClr  = 1'b1;
                        w_stateNext = DONE;
                    end else begin
                        w_ptrStep = 1'b1;
                        w_capture = 1'b1;
                    end
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Dump pointer, stream output registers and high-water mark. The RAM
    // array itself is deliberately outside this reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr       <= '0;
            r_hwm       <= '0;
            r_dumpData  <= '0;
            r_dumpValid <= 1'b0;
        end else begin
            r_hwm <= w_hwmNext;
            if (w_ptrClr) begin
                r_ptr <= '0;
            end else if (w_ptrStep) begin
                r_ptr <= r_ptr + PTR_ONE;
            end
            if (w_capture) begin
                r_dumpData <= w_ramDump;
            end
            if (w_validSet) begin
                r_dumpValid <= 1'b1;
            end else if (w_validClr) begin
                r_dumpValid <= 1'b0;
            end
        end
    end

    // Sticky error flags. Out-of-range is sampled at the edge, so a bad
    // address only counts once it has been held through a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_errOor  <= 1'b0;
            r_errBusy <= 1'b0;
        end else begin
            if (!w_addrInRange) begin
                r_errOor <= 1'b1;
            end
            if (we && !w_idle) begin
                r_errBusy <= 1'b1;
            end
        end
    end

    assign dump_data  = r_dumpData;
    assign dump_valid = r_dumpValid;
    assign dump_done  = w_done;
    assign busy       = !w_idle;
    assign hwm        = r_hwm;
    assign err_oor    = r_errOor;
    assign err_busy   = r_errBusy;

endmodule

// File: tb/tb_dmem_result_writer.sv
// tb_dmem_result_writer
// Directed bench for dmem_result_writer. Expected dump words are queued when a
// dump is requested; a monitor pops and compares every word the sink accepts.
module tb_dmem_result_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] address;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        dump_start;
    logic [31:0] dump_data;
    logic        dump_valid;
    logic        dump_ready;
    logic        dump_done;
    logic        busy;
    logic [13:0] hwm;
    logic        err_oor;
    logic        err_busy;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] expQ [$];
    int          acceptCount = 0;
    int          firstAcceptCyc = 0;
    int          lastAcceptCyc = 0;
    logic        prevHold = 1'b0;
    logic [31:0] prevData = '0;
    logic        stopReady = 1'b0;
    logic [3:0]  readyPat = 4'b1001;
    int          sc;
    int          dc;

    dmem_result_writer dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .address    (address),
        .wd         (wd),
        .rd         (rd),
        .dump_start (dump_start),
        .dump_data  (dump_data),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_done  (dump_done),
        .busy       (busy),
        .hwm        (hwm),
        .err_oor    (err_oor),
        .err_busy   (err_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One core cycle: drive the store port, let an edge pass, drop the strobe.
    task automatic applyStimulus(input logic iWe, input logic [31:0] iAddr, input logic [31:0] iWd);
        we      = iWe;
        address = iAddr;
        wd      = iWd;
        step();
        we = 1'b0;
    endtask

    task automatic startDump(output int startCyc);
        startCyc   = cyc;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
    endtask

    task automatic waitDone(input int budget, output int doneCyc);
        doneCyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dump_done) begin
                doneCyc = cyc;
                break;
            end
        end
        if (doneCyc < 0) begin
            total++;
            bad++;
            $display("[TB] FAIL done_timeout actual=none expected=dump_done within %0d cycles", budget);
        end
    endtask

    // Monitor: pops the scoreboard on each accepted word, checks that a
    // stalled word stays put, and that completion leaves nothing pending.
    always @(negedge clk) begin
        if (reset) begin
            prevHold = 1'b0;
        end else begin
            if (prevHold) begin
                checkOutput("hold_valid", {31'b0, dump_valid}, 32'd1);
                checkOutput("hold_data", dump_data, prevData);
            end
            if (dump_valid && dump_ready) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_word actual=0x%0h expected=no word", dump_data);
                end else begin
                    checkOutput("dump_word", dump_data, expQ.pop_front());
                end
                if (acceptCount == 0) firstAcceptCyc = cyc;
                lastAcceptCyc = cyc;
                acceptCount++;
            end
            if (dump_done) begin
                checkOutput("done_queue_empty", 32'(expQ.size()), 32'd0);
            end
            prevHold = dump_valid && !dump_ready;
            prevData = dump_data;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        we         = 1'b0;
        address    = 32'd0;
        wd         = 32'd0;
        dump_start = 1'b0;
        dump_ready = 1'b1;
        repeat (2) step();

        // Reset state
        checkOutput("rst_valid", {31'b0, dump_valid}, 32'd0);
        checkOutput("rst_done", {31'b0, dump_done}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_hwm", {18'b0, hwm}, 32'd0);
        checkOutput("rst_err_oor", {31'b0, err_oor}, 32'd0);
        checkOutput("rst_err_busy", {31'b0, err_busy}, 32'd0);
        checkOutput("rst_dump_data", dump_data, 32'd0);
        reset = 1'b0;
        step();

        // Basic stores and combinational load
        applyStimulus(1'b1, 32'd0, 32'h10);
        applyStimulus(1'b1, 32'd1, 32'h20);
        applyStimulus(1'b1, 32'd2, 32'h30);
        address = 32'd1;
        #1;
        checkOutput("t1_rd1", rd, 32'h20);
        checkOutput("t1_hwm", {18'b0, hwm}, 32'd3);
        checkOutput("t1_err_oor", {31'b0, err_oor}, 32'd0);

        // Dump with constant ready
        acceptCount = 0;
        expQ.push_back(32'h10);
        expQ.push_back(32'h20);
        expQ.push_back(32'h30);
        startDump(sc);
        waitDone(40, dc);
        checkOutput("t2_first_latency", 32'(firstAcceptCyc - sc), 32'd2);
        checkOutput("t2_back_to_back", 32'(lastAcceptCyc - firstAcceptCyc), 32'd2);
        checkOutput("t2_words", 32'(acceptCount), 32'd3);
        checkOutput("t2_done_after_last", 32'(dc - lastAcceptCyc), 32'd1);
        step();
        checkOutput("t2_busy_after", {31'b0, busy}, 32'd0);
        checkOutput("t2_done_one_cycle", {31'b0, dump_done}, 32'd0);
        checkOutput("t2_hwm_kept", {18'b0, hwm}, 32'd3);

        // Dump with a stalling sink
        acceptCount = 0;
        stopReady   = 1'b0;
        expQ.push_back(32'h10);
        expQ.push_back(32'h20);
        expQ.push_back(32'h30);
        fork
            begin
                startDump(sc);
                waitDone(80, dc);
                stopReady = 1'b1;
            end
            begin
                for (int i = 0; i < 80 && !stopReady; i++) begin
                    dump_ready = readyPat[i % 4];
                    step();
                end
            end
        join
        dump_ready = 1'b1;
        checkOutput("t3_words", 32'(acceptCount), 32'd3);
        checkOutput("t3_busy_after", {31'b0, busy}, 32'd0);

        // Store attempted while the dump is stalled in SEND
        acceptCount = 0;
        dump_ready  = 1'b0;
        expQ.push_back(32'h10);
        expQ.push_back(32'h20);
        expQ.push_back(32'h30);
        startDump(sc);
        step();
        step();
        applyStimulus(1'b1, 32'd1, 32'hBAD);
        checkOutput("t5_err_busy", {31'b0, err_busy}, 32'd1);
        checkOutput("t5_busy", {31'b0, busy}, 32'd1);
        dump_ready = 1'b1;
        waitDone(40, dc);
        step();
        checkOutput("t5_words", 32'(acceptCount), 32'd3);
        checkOutput("t5_rd_unchanged", rd, 32'h20);
        checkOutput("t5_hwm", {18'b0, hwm}, 32'd3);

        // Out-of-range store and the top boundary
        applyStimulus(1'b1, 32'd8100, 32'hDEAD);
        checkOutput("t4_err_oor", {31'b0, err_oor}, 32'd1);
        checkOutput("t4_hwm_unchanged", {18'b0, hwm}, 32'd3);
        checkOutput("t4_rd_oor", rd, 32'd0);
        applyStimulus(1'b1, 32'd8099, 32'h55);
        checkOutput("t4_hwm_full", {18'b0, hwm}, 32'd8100);
        checkOutput("t4_rd_top", rd, 32'h55);
        checkOutput("t4_err_busy_sticky", {31'b0, err_busy}, 32'd1);

        // Reset clears the flags and the high-water mark
        reset = 1'b1;
        step();
        checkOutput("rst2_hwm", {18'b0, hwm}, 32'd0);
        checkOutput("rst2_err_oor", {31'b0, err_oor}, 32'd0);
        checkOutput("rst2_err_busy", {31'b0, err_busy}, 32'd0);
        address = 32'd0;
        reset   = 1'b0;
        step();

        // Empty dump completes without any word
        acceptCount = 0;
        startDump(sc);
        waitDone(10, dc);
        checkOutput("t5b_done_latency", 32'(dc - sc), 32'd1);
        checkOutput("t5b_no_words", 32'(acceptCount), 32'd0);
        step();
        checkOutput("t5b_busy_after", {31'b0, busy}, 32'd0);

        // Same-cycle store and load of one word shows the old value
        applyStimulus(1'b1, 32'd0, 32'hAA);
        we      = 1'b1;
        address = 32'd0;
        wd      = 32'hBB;
        #1;
        checkOutput("rw_old_word", rd, 32'hAA);
        step();
        we = 1'b0;
        checkOutput("rw_new_word", rd, 32'hBB);
        applyStimulus(1'b1, 32'd1, 32'hCC);
        applyStimulus(1'b1, 32'd2, 32'hDD);
        checkOutput("t6_hwm_before", {18'b0, hwm}, 32'd3);

        // Reset in the middle of a stalled dump
        dump_ready = 1'b0;
        startDump(sc);
        step();
        checkOutput("t6_valid_before", {31'b0, dump_valid}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("t6_valid_reset", {31'b0, dump_valid}, 32'd0);
        checkOutput("t6_busy_reset", {31'b0, busy}, 32'd0);
        checkOutput("t6_hwm_reset", {18'b0, hwm}, 32'd0);
        step();
        reset = 1'b0;
        step();
        address = 32'd0;
        #1;
        checkOutput("t6_ram_kept0", rd, 32'hBB);
        address = 32'd2;
        #1;
        checkOutput("t6_ram_kept2", rd, 32'hDD);
        dump_ready = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
